// File: rtl/drive_mode_ctrl_pkg.sv
// Shared FSM encodings, mode codes and timing defaults for the drive-mode
// controller, engine and datapath blocks.
package drive_mode_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_PRESS = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_SEMI   = 2'b10,
        MODE_AUTO   = 2'b11
    } mode_e;

    localparam int DEF_CLK_PER_MS = 100000;
    localparam int DEF_HOLD_MS    = 1000;
    localparam int DEF_WDOG_MS    = 2000;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/drive_mode_ctrl_ms_tick.sv
// Free-running 1 ms divider: counts 0..CLK_PER_MS-1 and pulses tick on wrap.
module ms_tick_gen
    import drive_mode_ctrl_pkg::*;
#(
    parameter int CLK_PER_MS = DEF_CLK_PER_MS
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int             W    = cnt_w(CLK_PER_MS - 1);
    localparam logic [W-1:0]   LAST = W'(CLK_PER_MS - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)              cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/drive_mode_ctrl.sv
// Power-button / mode-select sequencer: hold-to-start, engine power handshake
// with watchdog, mode changes while running, and latched fault.
module drive_mode_ctrl
    import drive_mode_ctrl_pkg::*;
#(
    parameter int CLK_PER_MS = DEF_CLK_PER_MS,
    parameter int HOLD_MS    = DEF_HOLD_MS,
    parameter int WDOG_MS    = DEF_WDOG_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_power,
    input  logic [1:0] mode_sw,
    input  logic       engine_power,
    output logic [1:0] global_state,
    output logic       power_on,
    output logic       power_off,
    output logic       fault,
    output logic [2:0] state_dbg
);
    localparam int           HW        = cnt_w(HOLD_MS);
    localparam int           WW        = cnt_w(WDOG_MS);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_MS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(WDOG_MS - 1);

    state_e        state;
    logic [HW-1:0] hold_cnt;
    logic [WW-1:0] wd_cnt;
    logic          btn_q, btn_armed, low_arm, tick, btn_rise;

    ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // btn_armed masks the first cycle out of reset so a held button is not an edge.
    assign btn_rise  = btn_armed & btn_power & ~btn_q;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_OFF;
            global_state <= MODE_OFF;
            power_on     <= 1'b0;
            power_off    <= 1'b0;
            fault        <= 1'b0;
            hold_cnt     <= '0;
            wd_cnt       <= '0;
            low_arm      <= 1'b0;
            btn_q        <= 1'b0;
            btn_armed    <= 1'b0;
        end else begin
            btn_q     <= btn_power;
            btn_armed <= 1'b1;
            case (state)
                ST_OFF: if (btn_power) begin
                    state    <= ST_PRESS;
                    hold_cnt <= '0;
                end
                ST_PRESS: begin
                    if (!btn_power) begin
                        state <= ST_OFF;
                    end else if (hold_cnt == HOLD_MAX) begin
                        // Held long enough with no mode selected: wait here for one.
                        if (mode_sw != MODE_OFF) begin
                            state        <= ST_START;
                            global_state <= mode_sw;
                            power_on     <= 1'b1;
                            wd_cnt       <= '0;
                        end
                    end else if (tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_LAST && mode_sw != MODE_OFF) begin
                            state        <= ST_START;
                            global_state <= mode_sw;
                            power_on     <= 1'b1;
                            wd_cnt       <= '0;
                        end
                    end
                end
                ST_START: begin
                    if (engine_power) begin
                        state    <= ST_RUN;
                        power_on <= 1'b0;
                        low_arm  <= 1'b0;
                    end else if (tick) begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt == WD_LAST) begin
                            state        <= ST_FAULT;
                            power_on     <= 1'b0;
                            power_off    <= 1'b1;
                            fault        <= 1'b1;
                            global_state <= MODE_OFF;
                        end
                    end
                end
                ST_RUN: begin
                    if (btn_rise) begin
                        state     <= ST_STOP;
                        power_off <= 1'b1;
                        wd_cnt    <= '0;
                    end else if (mode_sw != global_state && mode_sw != MODE_OFF) begin
                        state        <= ST_START;
                        global_state <= mode_sw;
                        power_on     <= 1'b1;
                        wd_cnt       <= '0;
                    end else if (engine_power) begin
                        low_arm <= 1'b0;
                    end else if (tick) begin
                        // Low at two consecutive ticks with no high between = a full period.
                        if (low_arm) begin
                            state    <= ST_START;
                            power_on <= 1'b1;
                            wd_cnt   <= '0;
                        end else begin
                            low_arm <= 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (!engine_power) begin
                        state        <= ST_OFF;
                        power_off    <= 1'b0;
                        global_state <= MODE_OFF;
                    end else if (tick) begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt == WD_LAST) begin
                            state        <= ST_FAULT;
                            fault        <= 1'b1;
                            global_state <= MODE_OFF;
                        end
                    end
                end
                ST_FAULT: if (btn_rise) begin
                    state     <= ST_OFF;
                    power_off <= 1'b0;
                    fault     <= 1'b0;
                end
                default: state <= ST_OFF;
            endcase
        end
    end
endmodule

// File: doc/drive_mode_ctrl.md
DRIVE_MODE_CTRL -- requirements
Module: drive_mode_ctrl

Interface
REQ-001 Parameter CLK_PER_MS, default 100000, system clocks per 1 ms tick.
REQ-002 Parameter HOLD_MS, default 1000, ms of continuous btn_power high needed to start.
REQ-003 Parameter WDOG_MS, default 2000, ms allowed for engine_power to follow a request.
REQ-004 clk  input  1  system clock; sole clock of the block.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_power  input  1  debounced power button level.
REQ-007 mode_sw  input  2  requested mode: 01 manual, 10 semi-auto, 11 auto, 00 none.
REQ-008 engine_power  input  1  engine power feedback (engine's next_power).
REQ-009 global_state  output  2  mode broadcast to engine and datapath; 00 means off.
REQ-010 power_on  output  1  level request to engine to power up.
REQ-011 power_off  output  1  level request to engine to power down.
REQ-012 fault  output  1  watchdog fault flag.
REQ-013 state_dbg  output  3  current FSM state encoding.

Function
REQ-014 The ms tick counter SHALL run 0..CLK_PER_MS-1 and wrap, producing a one-cycle tick at wrap; all ms counters SHALL advance only on tick.
REQ-015 FSM states SHALL be OFF, PRESS, START, RUN, STOP, FAULT.
REQ-016 OFF: outputs 00/0/0; btn_power high -> PRESS with hold counter cleared.
REQ-017 PRESS: hold counter +1 per tick; btn_power low -> OFF; count reaching HOLD_MS with mode_sw != 00 -> START with global_state <= mode_sw; count reaching HOLD_MS with mode_sw == 00 -> saturate, stay in PRESS.
REQ-018 START: power_on = 1, watchdog counter cleared on entry; engine_power high -> RUN; watchdog reaching WDOG_MS -> FAULT.
REQ-019 RUN: power_on = 0, power_off = 0; btn_power rising edge -> STOP; mode_sw differing from global_state and != 00 -> global_state <= mode_sw, -> START; engine_power low for a full tick period -> START.
REQ-020 Simultaneous btn_power rising edge and mode change in RUN: STOP SHALL win; global_state unchanged.
REQ-021 STOP: power_off = 1, global_state held; engine_power low -> OFF with global_state <= 00; watchdog reaching WDOG_MS -> FAULT.
REQ-022 FAULT: global_state = 00, power_off = 1, fault = 1; btn_power rising edge -> OFF with fault cleared.
REQ-023 Edge detect SHALL use a registered copy of btn_power; the first cycle after reset SHALL NOT register an edge.
REQ-024 All outputs SHALL be registered; a state change is visible on outputs one clk after the deciding edge.
REQ-025 Counters SHALL be sized for their parameter maximum and SHALL saturate, never wrap, except the ms divider.

Reset
REQ-026 On rst high at a clk edge: state OFF, global_state 00, power_on 0, power_off 0, fault 0, all counters 0, edge register 0.
REQ-027 rst SHALL take priority over every other input, including mid-START or mid-STOP.

Structure
REQ-028 State encodings, mode codes (OFF/MANUAL/SEMI/AUTO) and default timing constants SHALL live in a shared package used by engine and datapath blocks.
REQ-029 The ms divider SHALL be one sub-module, ms_tick_gen, parameterised by CLK_PER_MS.

Verification (CLK_PER_MS=10, HOLD_MS=5, WDOG_MS=4)
REQ-030 btn_power high 60 clks with mode_sw=01, engine_power follows power_on after 20 clks -> START then RUN, global_state 01, power_on 1 then 0.
REQ-031 btn_power high 30 clks then low -> back to OFF, global_state 00, power_on never asserted.
REQ-032 In RUN at 01, mode_sw -> 11, engine drops power -> global_state 11, START, power_on 1, RUN again once engine_power high.
REQ-033 In START, engine_power held low -> FAULT after 4 ticks (40 clks), fault 1, power_off 1; btn_power rising edge -> OFF, fault 0.
REQ-034 In RUN, btn_power rising edge and mode_sw change same cycle -> STOP, global_state unchanged, power_off 1; engine_power low -> OFF, global_state 00.
REQ-035 rst asserted mid-START -> next clk all outputs at reset values, state_dbg = OFF.
